// File: rtl/z88_pkg.sv
// Shared Z88 definitions: arbiter state encoding and memory-interface defaults.
package z88_pkg;

    localparam int unsigned MA_W_DEFAULT      = 22;
    localparam int unsigned BURST_LEN_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        LCD_ADDR,
        LCD_DATA
    } arb_state_t;

    function automatic logic is_lcd_state(input arb_state_t s);
        return (s == LCD_ADDR) || (s == LCD_DATA);
    endfunction

endpackage

// File: rtl/lcd_starve_timer.sv
// Saturating LCD wait counter; raises starve once lcd_req has waited STARVE_MAX cycles.
module lcd_starve_timer #(
    parameter int unsigned STARVE_MAX = 48
) (
    input  logic mck,
    input  logic rin_n,
    input  logic lcd_req,
    input  logic in_lcd,
    input  logic clear,
    output logic starve
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (lcd_req && !in_lcd && (cnt != CNT_W'(STARVE_MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/lcd_mem_arb.sv
// Z80 / LCD shared-memory arbiter; CPU has priority, LCD bursts up to BURST_LEN bytes.
// Define LCD_STARVE_GUARD_EN to let a long-waiting LCD request pre-empt the CPU.
module lcd_mem_arb
    import z88_pkg::*;
#(
    parameter int unsigned MA_W       = MA_W_DEFAULT,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT,
    parameter int unsigned STARVE_MAX = 48
) (
    input  logic            mck,
    input  logic            rin_n,
    input  logic            cpu_req,
    input  logic [MA_W-1:0] cpu_ma,
    input  logic            cpu_oe_n,
    input  logic            cpu_we_n,
    output logic            cpu_wait_n,
    input  logic            lcd_req,
    input  logic [MA_W-1:0] lcd_ma,
    output logic            lcd_dvalid,
    output logic [7:0]      lcd_rdata,
    output logic [MA_W-1:0] mem_ma,
    input  logic [7:0]      mem_di,
    output logic            mem_oe_n,
    output logic            mem_we_n
);

    localparam int unsigned BC_W = $clog2(BURST_LEN + 1);

    if (BURST_LEN == 0 || STARVE_MAX == 0) begin : g_bad_cfg
        $error("lcd_mem_arb: BURST_LEN and STARVE_MAX must be non-zero");
    end

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [BC_W-1:0] burst_cnt;
    logic [MA_W-1:0] lcd_ma_q;
    logic            starve_flag;

`ifdef LCD_STARVE_GUARD_EN
    logic lcd_grant;
    logic in_lcd;

    assign lcd_grant = (state_nxt == LCD_ADDR);
    assign in_lcd    = is_lcd_state(state);

    lcd_starve_timer #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_timer (
        .mck    (mck),
        .rin_n  (rin_n),
        .lcd_req(lcd_req),
        .in_lcd (in_lcd),
        .clear  (lcd_grant),
        .starve (starve_flag)
    );
`else
    assign starve_flag = 1'b0;
`endif

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req && !(starve_flag && lcd_req)) begin
                    state_nxt = CPU;
                end else if (lcd_req) begin
                    state_nxt = LCD_ADDR;
                end
            end
            CPU: begin
                if (!cpu_req) begin
                    state_nxt = IDLE;
                end
            end
            LCD_ADDR: state_nxt = LCD_DATA;
            LCD_DATA: begin
                if (lcd_req && (burst_cnt < BC_W'(BURST_LEN)) && !cpu_req) begin
                    state_nxt = LCD_ADDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // burst_cnt counts bytes started; the address is latched so LCD_DATA holds the bus
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            burst_cnt  <= '0;
            lcd_ma_q   <= '0;
            lcd_rdata  <= '0;
            lcd_dvalid <= 1'b0;
        end else begin
            lcd_dvalid <= (state == LCD_DATA);
            case (state)
                IDLE: burst_cnt <= '0;
                LCD_ADDR: begin
                    burst_cnt <= burst_cnt + 1'b1;
                    lcd_ma_q  <= lcd_ma;
                end
                LCD_DATA: lcd_rdata <= mem_di;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_ma   = cpu_ma;
        mem_oe_n = cpu_oe_n;
        mem_we_n = cpu_we_n;
        case (state)
            LCD_ADDR: begin
                mem_ma   = lcd_ma;
                mem_oe_n = 1'b0;
                mem_we_n = 1'b1;
            end
            LCD_DATA: begin
                mem_ma   = lcd_ma_q;
                mem_oe_n = 1'b0;
                mem_we_n = 1'b1;
            end
            default: ;
        endcase
        // strobes are passed through combinationally, so reset must gate them directly
        if (!rin_n) begin
            mem_oe_n = 1'b1;
            mem_we_n = 1'b1;
        end
    end

    assign cpu_wait_n = !(cpu_req && is_lcd_state(state));

endmodule

// File: tb/tb_lcd_mem_arb.sv
// Self-checking bench for lcd_mem_arb: directed scenarios plus random traffic vs. a grant-level model.
// Honours LCD_STARVE_GUARD_EN to pick the matching starvation scenario.
module tb_lcd_mem_arb;

    localparam int unsigned MA_W       = 22;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned STARVE_MAX = 48;

    logic            mck;
    logic            rin_n;
    logic            cpu_req;
    logic [MA_W-1:0] cpu_ma;
    logic            cpu_oe_n;
    logic            cpu_we_n;
    logic            cpu_wait_n;
    logic            lcd_req;
    logic [MA_W-1:0] lcd_ma;
    logic            lcd_dvalid;
    logic [7:0]      lcd_rdata;
    logic [MA_W-1:0] mem_ma;
    logic [7:0]      mem_di;
    logic            mem_oe_n;
    logic            mem_we_n;

    lcd_mem_arb #(
        .MA_W      (MA_W),
        .BURST_LEN (BURST_LEN),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .mck       (mck),
        .rin_n     (rin_n),
        .cpu_req   (cpu_req),
        .cpu_ma    (cpu_ma),
        .cpu_oe_n  (cpu_oe_n),
        .cpu_we_n  (cpu_we_n),
        .cpu_wait_n(cpu_wait_n),
        .lcd_req   (lcd_req),
        .lcd_ma    (lcd_ma),
        .lcd_dvalid(lcd_dvalid),
        .lcd_rdata (lcd_rdata),
        .mem_ma    (mem_ma),
        .mem_di    (mem_di),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus (0 none, 1 cpu, 2 lcd address phase, 3 lcd data phase)
    int              m_owner;
    int              m_bytes;
    int              m_starve;
    logic            m_dv;
    logic [7:0]      m_rdata;
    logic [MA_W-1:0] m_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_bytes  = 0;
        m_starve = 0;
        m_dv     = 1'b0;
        m_rdata  = 8'h00;
        m_hold   = '0;
    endtask

    task automatic model_edge();
        int nxt;
        bit flag;
`ifdef LCD_STARVE_GUARD_EN
        flag = (m_starve >= int'(STARVE_MAX));
`else
        flag = 1'b0;
`endif
        nxt  = m_owner;
        m_dv = 1'b0;
        case (m_owner)
            0: begin
                if (cpu_req && !(flag && lcd_req)) nxt = 1;
                else if (lcd_req) begin
                    nxt     = 2;
                    m_bytes = 0;
                end
            end
            1: nxt = cpu_req ? 1 : 0;
            2: begin
                nxt    = 3;
                m_hold = lcd_ma;
                m_bytes++;
            end
            default: begin
                m_rdata = mem_di;
                m_dv    = 1'b1;
                nxt     = (lcd_req && m_bytes < int'(BURST_LEN) && !cpu_req) ? 2 : 0;
            end
        endcase
        if (nxt == 2) m_starve = 0;
        else if (m_owner < 2 && lcd_req && m_starve < int'(STARVE_MAX)) m_starve++;
        m_owner = nxt;
    endtask

    task automatic check_model();
        logic [MA_W-1:0] ema;
        logic            eoe;
        logic            ewe;
        ema = cpu_ma;
        eoe = cpu_oe_n;
        ewe = cpu_we_n;
        if (m_owner == 2) begin
            ema = lcd_ma;  eoe = 1'b0; ewe = 1'b1;
        end else if (m_owner == 3) begin
            ema = m_hold;  eoe = 1'b0; ewe = 1'b1;
        end
        if (!rin_n) begin
            eoe = 1'b1;
            ewe = 1'b1;
        end
        chk("mem_ma",     32'(mem_ma),     32'(ema));
        chk("mem_oe_n",   32'(mem_oe_n),   32'(eoe));
        chk("mem_we_n",   32'(mem_we_n),   32'(ewe));
        chk("cpu_wait_n", 32'(cpu_wait_n), 32'(!(cpu_req && m_owner >= 2)));
        chk("lcd_dvalid", 32'(lcd_dvalid), 32'(m_dv));
        chk("lcd_rdata",  32'(lcd_rdata),  32'(m_rdata));
    endtask

    // Called at a negedge with inputs already set; leaves time at the next negedge.
    task automatic cycle();
        #1;
        check_model();
        @(posedge mck);
        if (rin_n) model_edge();
        @(negedge mck);
    endtask

    task automatic apply_reset();
        rin_n = 1'b0;
        #1;
        model_reset();
        chk("rst_oe_n",   32'(mem_oe_n),   32'd1);
        chk("rst_we_n",   32'(mem_we_n),   32'd1);
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("rst_dvalid", 32'(lcd_dvalid), 32'd0);
        chk("rst_rdata",  32'(lcd_rdata),  32'd0);
        @(posedge mck);
        @(negedge mck);
        rin_n = 1'b1;
    endtask

    initial begin
        int dv_cnt;
        int last_dv;
        int waits;
        bit found;
        int idx;

        rin_n    = 1'b0;
        cpu_req  = 1'b0;
        cpu_ma   = '0;
        cpu_oe_n = 1'b0;
        cpu_we_n = 1'b0;
        lcd_req  = 1'b0;
        lcd_ma   = 22'h000100;
        mem_di   = 8'h5A;
        model_reset();
        @(negedge mck);

        // Reset state with CPU strobes low: the shared strobes must still read inactive
        apply_reset();

        // CPU only: address passes straight through, never stalled
        cpu_oe_n = 1'b0;
        cpu_we_n = 1'b1;
        cpu_req  = 1'b1;
        cpu_ma   = 22'h200010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cpu_only_ma",   32'(mem_ma),     32'h200010);
            chk("cpu_only_wait", 32'(cpu_wait_n), 32'd1);
            cycle();
        end
        cpu_req  = 1'b0;
        cpu_oe_n = 1'b1;
        cycle();

        // LCD burst: four bytes, two cycles apart, then back to idle
        dv_cnt  = 0;
        last_dv = -1;
        for (int k = 0; k < 12; k++) begin
            lcd_req = (k < 9);
            mem_di  = 8'(8'h30 + k);
            #1;
            if (lcd_dvalid) begin
                if (last_dv >= 0) chk("burst_gap", 32'(k - last_dv), 32'd2);
                last_dv = k;
                dv_cnt++;
            end
            if (k == 11) chk("burst_idle_oe", 32'(mem_oe_n), 32'(cpu_oe_n));
            cycle();
        end
        chk("burst_pulses", 32'(dv_cnt), 32'd4);

        // CPU arrives during LCD_ADDR: two stall cycles, byte completes, CPU then granted
        waits  = 0;
        dv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            lcd_req = (k < 3);
            if (k == 1) begin
                cpu_req = 1'b1;
                cpu_ma  = 22'h0ABCDE;
            end
            #1;
            if (k == 1) chk("mid_lcd_addr_oe", 32'(mem_oe_n), 32'd0);
            if (!cpu_wait_n) waits++;
            if (lcd_dvalid) dv_cnt++;
            if (k == 4) chk("mid_cpu_granted_ma", 32'(mem_ma), 32'h0ABCDE);
            cycle();
        end
        chk("mid_wait_cycles", 32'(waits), 32'd2);
        chk("mid_byte_done",   32'(dv_cnt), 32'd1);
        cpu_req = 1'b0;
        cycle();

        // Starvation: CPU re-requests every other cycle while the LCD waits
        @(negedge mck);
        apply_reset();
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
        lcd_req  = 1'b1;
        found    = 1'b0;
        idx      = -1;
`ifdef LCD_STARVE_GUARD_EN
        for (int k = 0; k < 60; k++) begin
            cpu_req = (k % 2 == 0);
            #1;
            if (!found && !mem_oe_n) begin
                found = 1'b1;
                idx   = k;
            end
            cycle();
        end
        chk("starve_grant_seen", 32'(found), 32'd1);
        chk("starve_grant_by_50", 32'(found && idx <= 50), 32'd1);
`else
        for (int k = 0; k < 200; k++) begin
            cpu_req = (k % 2 == 0);
            #1;
            if (!mem_oe_n) found = 1'b1;
            cycle();
        end
        chk("no_guard_no_lcd_grant", 32'(found), 32'd0);
`endif
        cpu_req = 1'b0;
        lcd_req = 1'b0;
        for (int k = 0; k < 6; k++) cycle();

        // Asynchronous reset while in LCD_DATA
        mem_di  = 8'hC3;
        lcd_req = 1'b1;
        cycle();
        cycle();
        #2;
        chk("pre_rst_in_data", 32'(mem_oe_n), 32'd0);
        rin_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_oe",     32'(mem_oe_n),   32'd1);
        chk("async_rst_we",     32'(mem_we_n),   32'd1);
        chk("async_rst_dvalid", 32'(lcd_dvalid), 32'd0);
        chk("async_rst_rdata",  32'(lcd_rdata),  32'd0);
        chk("async_rst_ma",     32'(mem_ma),     32'(cpu_ma));
        @(negedge mck);
        rin_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        lcd_req = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        // Random traffic against the model; the LCD requester advances its address on each byte
        for (int k = 0; k < 500; k++) begin
            cpu_req  = ($urandom_range(0, 2) == 0);
            lcd_req  = ($urandom_range(0, 3) != 0);
            cpu_ma   = MA_W'($urandom);
            cpu_oe_n = 1'($urandom);
            cpu_we_n = 1'($urandom);
            mem_di   = 8'($urandom);
            if (lcd_dvalid) lcd_ma = lcd_ma + 1'b1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
